// File: rtl/seg_scan_ctrl.sv
// Scans an NDIG-digit BCD buffer onto one active-low digit select plus its nibble.
// Outputs decode from registers (lzb_en gating aside); in_ready falls while an update awaits the next frame boundary.
module seg_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int DWELL = 50000,
  parameter int GUARD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [4*NDIG-1:0] in_data,
  output logic              in_ready,
  input  logic              lzb_en,
  output logic [NDIG-1:0]   dig_sel_n,
  output logic [3:0]        bcd_out,
  output logic              frame_done
);

  localparam int MAXC = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NDIG);

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [IW-1:0]     idx, idx_nxt;
  logic [4*NDIG-1:0] disp, shadow;
  logic              pending;
  logic              boundary;
  logic [NDIG-1:0]   lead_zero;
  logic              blank_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= IDX_LAST;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    boundary  = 1'b0;
    case (state)
      SHOW: begin
        if (cnt == DWELL_LAST) begin
          state_nxt = BLANK;
          cnt_nxt   = '0;
        end
      end
      BLANK: begin
        if (cnt == GUARD_LAST) begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
          if (idx == IDX_LAST) begin
            idx_nxt  = '0;
            boundary = 1'b1;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      default: begin
        state_nxt = BLANK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Commit and accept are exclusive: accept needs pending=0, commit needs pending=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp    <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else if (boundary && pending) begin
      disp    <= shadow;
      pending <= 1'b0;
    end else if (in_valid && !pending) begin
      shadow  <= in_data;
      pending <= 1'b1;
    end
  end

  // lead_zero[i]: digits i..NDIG-1 are all zero.
  for (genvar i = 0; i < NDIG; i++) begin : g_lz
    assign lead_zero[i] = ~|disp[4*NDIG-1:4*i];
  end

  assign blank_cur = lzb_en && (idx != '0) && lead_zero[idx];

  always_comb begin
    dig_sel_n = '1;
    if (state == SHOW && !blank_cur) dig_sel_n[idx] = 1'b0;
  end

  assign bcd_out    = disp[{idx, 2'b00} +: 4];
  assign in_ready   = !pending;
  assign frame_done = boundary;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboarded bench for seg_scan_ctrl: a frame-level model predicts every cycle's outputs.
module tb_seg_scan_ctrl;

  localparam int NDIG  = 4;
  localparam int DWELL = 4;
  localparam int GUARD = 2;
  localparam int SLOT  = DWELL + GUARD;
  localparam int FRAME = NDIG * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        lzb_en = 1'b0;
  logic        in_ready;
  logic [3:0]  dig_sel_n;
  logic [3:0]  bcd_out;
  logic        frame_done;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] bcd;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int   tag_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int          t = 0;
  logic [15:0] disp = '0;
  logic [15:0] shadow = '0;
  logic        pend = 1'b0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL), .GUARD(GUARD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .lzb_en     (lzb_en),
    .dig_sel_n  (dig_sel_n),
    .bcd_out    (bcd_out),
    .frame_done (frame_done)
  );

  // Frame position: each slot is GUARD dark cycles followed by DWELL lit cycles of digit 'slot'.
  function automatic exp_t exp_now();
    exp_t e;
    int p, slot, off, idx;
    p    = t % FRAME;
    slot = p / SLOT;
    off  = p % SLOT;
    idx  = (off < GUARD) ? (slot + NDIG - 1) % NDIG : slot;
    e.bcd = 4'((disp >> (4 * idx)) & 16'h000F);
    e.sel = 4'b1111;
    if (off >= GUARD && !(lzb_en && slot > 0 && (disp >> (4 * slot)) == 16'd0))
      e.sel[slot] = 1'b0;
    e.fd  = (p == GUARD - 1);
    e.rdy = !pend;
    return e;
  endfunction

  function automatic exp_t exp_reset();
    exp_t e;
    e.sel = 4'b1111;
    e.bcd = 4'h0;
    e.fd  = 1'b0;
    e.rdy = 1'b1;
    return e;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      int   tg;
      e  = exp_q.pop_front();
      tg = tag_q.pop_front();
      checks++;
      if (dig_sel_n !== e.sel || bcd_out !== e.bcd || frame_done !== e.fd || in_ready !== e.rdy) begin
        errors++;
        $display("FAIL out[t=%0d] got sel=%b bcd=%h fd=%b rdy=%b, want sel=%b bcd=%h fd=%b rdy=%b",
                 tg, dig_sel_n, bcd_out, frame_done, in_ready, e.sel, e.bcd, e.fd, e.rdy);
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic cycle(input logic v, input logic [15:0] d);
    in_valid = v;
    in_data  = d;
    exp_q.push_back(exp_now());
    tag_q.push_back(t);
    @(posedge clk);
    if ((t % FRAME) == GUARD - 1 && pend) begin
      disp = shadow;
      pend = 1'b0;
    end else if (v && !pend) begin
      shadow = d;
      pend   = 1'b1;
    end
    t++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0);
  endtask

  // Hold the offer until the model says it is taken (bounded by one frame).
  task automatic send(input logic [15:0] d);
    while (pend) cycle(1'b1, d);
    cycle(1'b1, d);
  endtask

  task automatic reset_cycles(input int n);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    t = 0; disp = '0; shadow = '0; pend = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_reset());
      tag_q.push_back(-1);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic run_to(input int phase);
    while ((t % FRAME) != phase) cycle(1'b0, 16'h0);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        hold_v;
    logic [15:0] hold_d;
    @(posedge clk);
    #1;
    reset_cycles(3);

    // power-up, scan order with 0x4321
    send(16'h4321);
    idle(2 * FRAME);

    // mid-frame update commits at the next boundary
    run_to(9);
    send(16'h8765);
    idle(FRAME + 4);

    // back-pressure: second offer held until first commits
    run_to(4);
    send(16'h1111);
    send(16'h2222);
    idle(2 * FRAME);

    // leading-zero blanking
    lzb_en = 1'b1;
    send(16'h0050);
    idle(2 * FRAME);
    send(16'h0000);
    idle(2 * FRAME);
    send(16'h0A0F);
    idle(2 * FRAME);

    // randomized traffic, lzb toggled only at frame start
    hold_v = 1'b0;
    hold_d = '0;
    for (int i = 0; i < 20 * FRAME; i++) begin
      if ((t % FRAME) == 0) lzb_en = 1'($urandom_range(0, 1));
      if (!(hold_v && pend)) begin
        hold_v = ($urandom_range(0, 3) == 0);
        for (int n = 0; n < 4; n++)
          hold_d[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      cycle(hold_v, hold_d);
    end

    // reset during SHOW of digit 2 with an update pending
    lzb_en = 1'b0;
    idle(FRAME);
    run_to(8);
    send(16'h9999);
    run_to(2 * SLOT + GUARD + 1);
    in_valid = 1'b0;
    exp_q.push_back(exp_now());
    tag_q.push_back(t);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sel", dig_sel_n, 4'b1111);
    chk("async_rst_bcd", bcd_out, 4'h0);
    chk("async_rst_rdy", {3'b0, in_ready}, 4'h1);
    chk("async_rst_fd", {3'b0, frame_done}, 4'h0);
    @(posedge clk);
    #1;
    reset_cycles(2);
    idle(2 * FRAME);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
